// File: rtl/div_pkg.sv
// div_pkg: shared types and widths for the 8-by-4 restoring divider.
// Holds FSM encodings, operand widths and the iteration count.
package div_pkg;

  localparam int DVD_W  = 8;
  localparam int DVS_W  = 4;
  localparam int PREM_W = 5;
  localparam int ITER   = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder cell.
// Used as the ripple element of the trial subtractor.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/trial_sub_5.sv
// trial_sub_5: 5-bit a - b as a ripple of full adders.
// b is inverted with carry-in 1; borrow is the inverted carry-out.
module trial_sub_5
  import div_pkg::*;
(
  input  logic [PREM_W-1:0] a,
  input  logic [PREM_W-1:0] b,
  output logic [PREM_W-1:0] diff,
  output logic              borrow
);

  logic [PREM_W:0] c;

  assign c[0] = 1'b1;

  for (genvar i = 0; i < PREM_W; i++) begin : g_fa
    full_adder u_fa (
      .a  (a[i]),
      .b  (~b[i]),
      .ci (c[i]),
      .s  (diff[i]),
      .co (c[i+1])
    );
  end

  assign borrow = ~c[PREM_W];

endmodule

// File: rtl/divide_8by4.sv
// divide_8by4: 8/4 unsigned restoring divider, one quotient bit per clock.
// DIVIDE_8BY4_ZERO_CHECK_EN: a zero divisor skips RUN and raises div_by_zero.
module divide_8by4
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DVD_W-1:0] Dividend,
  input  logic [DVS_W-1:0] Divisor,
  output logic [DVD_W-1:0] Quot,
  output logic [DVS_W-1:0] Rem,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_t state;
  state_t nxt;

  logic [DVD_W-1:0]  q;
  logic [DVD_W-1:0]  q_nx;
  logic [DVS_W-1:0]  d;
  logic [PREM_W-1:0] p;
  logic [PREM_W-1:0] p_nx;
  logic [PREM_W-1:0] a_t;
  logic [PREM_W-1:0] b_t;
  logic [PREM_W-1:0] diff;
  logic              borrow;
  logic [CNT_W-1:0]  cnt;
  logic              accept;
  logic              last;
  logic              skip;

  assign accept = (state == IDLE) && start;
  assign last   = (cnt == '0);

`ifdef DIVIDE_8BY4_ZERO_CHECK_EN
  assign skip = accept && (Divisor == '0);
`else
  assign skip = 1'b0;
`endif

  assign a_t = {p[DVS_W-1:0], q[DVD_W-1]};
  assign b_t = {1'b0, d};

  trial_sub_5 u_sub (
    .a      (a_t),
    .b      (b_t),
    .diff   (diff),
    .borrow (borrow)
  );

  assign p_nx = borrow ? a_t : diff;
  assign q_nx = {q[DVD_W-2:0], ~borrow};

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = skip ? DONE : RUN;
      RUN:  if (last)  nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state == RUN):  busy = 1'b1;
      (state == DONE): done = 1'b1;
      default: ;
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      d    <= '0;
      p    <= '0;
      cnt  <= '0;
      Quot <= '0;
      Rem  <= '0;
    end else if (accept) begin
      q   <= Dividend;
      d   <= Divisor;
      p   <= '0;
      cnt <= CNT_W'(ITER - 1);
      if (skip) begin
        Quot <= '1;
        Rem  <= Dividend[DVS_W-1:0];
      end
    end else if (state == RUN) begin
      q <= q_nx;
      p <= p_nx;
      if (!last) cnt <= cnt - 1'b1;
      if (last) begin
        Quot <= q_nx;
        Rem  <= p_nx[DVS_W-1:0];
      end
    end
  end

`ifdef DIVIDE_8BY4_ZERO_CHECK_EN
  logic dbz;

  // zero-divisor flag, refreshed on every accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dbz <= 1'b0;
    else if (accept) dbz <= skip;
  end

  assign div_by_zero = dbz;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule
